// File: rtl/tdc_result_framer_pkg.sv
// Shared constants, serializer state encoding and frame-byte helper for the TDC result framer.
package tdc_result_framer_pkg;

  localparam int         TDC_FINE_W     = 10;
  localparam int         TDC_RECORD_W   = 24;
  localparam int         TDC_FIFO_DEPTH = 16;
  localparam logic [7:0] TDC_HDR_BYTE   = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_B2,
    ST_B1,
    ST_B0
  } ser_state_e;

  // Byte presented on the stream while the serializer sits in state st.
  function automatic logic [7:0] frame_byte(input logic [TDC_RECORD_W-1:0] rec,
                                            input logic [7:0]              hdr,
                                            input ser_state_e              st);
    case (st)
      ST_HDR:  return hdr;
      ST_B2:   return rec[23:16];
      ST_B1:   return rec[15:8];
      ST_B0:   return rec[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/tdc_result_framer_fifo.sv
// Register-based synchronous FIFO with first-word-fall-through read data and a registered level.
module tdc_sync_fifo #(
  parameter  int WIDTH = 24,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  // A write into a full FIFO is dropped even if a pop happens on the same edge.
  assign full    = (r_level == LVL_W'(DEPTH));
  assign empty   = (r_level == '0);
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];
  assign level   = r_level;

  always_ff @(posedge iClk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/tdc_result_framer.sv
// Timestamps TDC conversions with a coarse counter, queues them, and streams 4-byte frames
// (header, record[23:16], record[15:8], record[7:0]) over a valid/ready byte interface.
module tdc_result_framer
  import tdc_result_framer_pkg::*;
#(
  parameter int         FINE_W     = TDC_FINE_W,
  parameter int         COARSE_W   = 14,
  parameter int         FIFO_DEPTH = TDC_FIFO_DEPTH,
  parameter logic [7:0] HDR_BYTE   = TDC_HDR_BYTE
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic [FINE_W-1:0]            iTDC,
  input  logic                         iDone,
  input  logic                         iClrOvf,
  output logic [7:0]                   oByte,
  output logic                         oValid,
  input  logic                         iReady,
  output logic                         oOverflow,
  output logic [$clog2(FIFO_DEPTH):0]  oLevel
);

  localparam int REC_W = FINE_W + COARSE_W;

  logic [COARSE_W-1:0] r_coarse;
  logic [REC_W-1:0]    r_hold;
  logic [7:0]          r_byte;
  logic                r_valid;
  logic                r_ovf;
  ser_state_e          r_state;

  logic [REC_W-1:0]    w_rd_data;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_hs;

  tdc_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iClk    (iClk),
    .iRst    (iRst),
    .wr_en   (iDone),
    .wr_data ({r_coarse, iTDC}),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (oLevel)
  );

  assign w_hs      = r_valid && iReady;
  assign oByte     = r_byte;
  assign oValid    = r_valid;
  assign oOverflow = r_ovf;

  // Pop from IDLE unconditionally, or from B0 on its final handshake so frames run back to back.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = !w_empty;
      ST_B0:   w_pop = w_hs && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_coarse <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_coarse <= r_coarse + COARSE_W'(1);
      if (iDone && w_full) r_ovf <= 1'b1;
      else if (iClrOvf)    r_ovf <= 1'b0;
    end
  end

  // Entering HDR from IDLE spends one cycle with oValid low while the holding register settles;
  // HDR with r_valid low therefore means "first presentation pending".
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_byte  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_hold  <= w_rd_data;
            r_state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_byte  <= frame_byte(r_hold, HDR_BYTE, ST_HDR);
          end else if (w_hs) begin
            r_byte  <= frame_byte(r_hold, HDR_BYTE, ST_B2);
            r_state <= ST_B2;
          end
        end
        ST_B2: begin
          if (w_hs) begin
            r_byte  <= frame_byte(r_hold, HDR_BYTE, ST_B1);
            r_state <= ST_B1;
          end
        end
        ST_B1: begin
          if (w_hs) begin
            r_byte  <= frame_byte(r_hold, HDR_BYTE, ST_B0);
            r_state <= ST_B0;
          end
        end
        ST_B0: begin
          if (w_hs) begin
            if (!w_empty) begin
              r_hold  <= w_rd_data;
              r_byte  <= frame_byte(w_rd_data, HDR_BYTE, ST_HDR);
              r_state <= ST_HDR;
            end else begin
              r_valid <= 1'b0;
              r_byte  <= 8'h00;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_byte  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_result_framer.sv
// Directed bench for tdc_result_framer: latency, backpressure, burst, overflow, wrap and reset abort.
module tb_tdc_result_framer;
  import tdc_result_framer_pkg::*;

  localparam int LVL_W = $clog2(TDC_FIFO_DEPTH) + 1;

  logic             iClk    = 1'b0;
  logic             iRst    = 1'b1;
  logic [9:0]       iTDC    = '0;
  logic             iDone   = 1'b0;
  logic             iClrOvf = 1'b0;
  logic             iReady  = 1'b0;
  logic [7:0]       oByte;
  logic             oValid;
  logic             oOverflow;
  logic [LVL_W-1:0] oLevel;

  tdc_result_framer dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iTDC      (iTDC),
    .iDone     (iDone),
    .iClrOvf   (iClrOvf),
    .oByte     (oByte),
    .oValid    (oValid),
    .iReady    (iReady),
    .oOverflow (oOverflow),
    .oLevel    (oLevel)
  );

  always #5 iClk = ~iClk;

  int          n_cmp = 0, n_err = 0;
  int          n_edge = 0, n_hs = 0, first_hs = -1, last_hs = -1, max_lvl = 0;
  int          guard;
  bit          chk_stall = 1'b0;
  logic [7:0]  q_b [$];
  logic [23:0] q_rec [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One clock: log the handshake about to happen, step past the edge, check stalled bytes held.
  task automatic cyc();
    bit         stall;
    logic [7:0] sb;
    stall = oValid && !iReady;
    sb    = oByte;
    if (oValid && iReady) begin
      q_b.push_back(oByte);
      if (first_hs < 0) first_hs = n_edge;
      last_hs = n_edge;
      n_hs++;
    end
    @(posedge iClk); #1;
    n_edge++;
    if (chk_stall && stall) begin
      chk("stall_vld", {31'd0, oValid}, 32'd1);
      chk("stall_byte", {24'd0, oByte}, {24'd0, sb});
    end
    if (int'(oLevel) > max_lvl) max_lvl = int'(oLevel);
  endtask

  task automatic do_reset();
    iRst = 1'b1; iDone = 1'b0; iClrOvf = 1'b0; iReady = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iRst   = 1'b0;
    n_edge = 0;
    q_b.delete();
    q_rec.delete();
  endtask

  task automatic check_frames(input string tag);
    logic [23:0] r;
    while (q_b.size() >= 4) begin
      chk({tag, "_hdr"}, {24'd0, q_b.pop_front()}, {24'd0, TDC_HDR_BYTE});
      r[23:16] = q_b.pop_front();
      r[15:8]  = q_b.pop_front();
      r[7:0]   = q_b.pop_front();
      chk({tag, "_rec_avail"}, (q_rec.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (q_rec.size() > 0) chk({tag, "_rec"}, {8'd0, r}, {8'd0, q_rec.pop_front()});
    end
    chk({tag, "_leftover_bytes"}, q_b.size(), 0);
    chk({tag, "_missing_recs"}, q_rec.size(), 0);
  endtask

  initial begin
    do_reset();
    chk("rst_byte", {24'd0, oByte}, 32'd0);
    chk("rst_vld", {31'd0, oValid}, 32'd0);
    chk("rst_ovf", {31'd0, oOverflow}, 32'd0);
    chk("rst_lvl", {27'd0, oLevel}, 32'd0);

    // Single hit at edge 20: record {14'd20, 10'h2B5} = 24'h0052B5
    iReady = 1'b1;
    repeat (20) cyc();
    iTDC = 10'h2B5; iDone = 1'b1; q_rec.push_back(24'h0052B5);
    cyc(); iDone = 1'b0;
    chk("lat_e20_vld", {31'd0, oValid}, 32'd0);
    chk("lat_e20_lvl", {27'd0, oLevel}, 32'd1);
    cyc();
    chk("lat_e21_vld", {31'd0, oValid}, 32'd0);
    cyc();
    chk("lat_e22_vld", {31'd0, oValid}, 32'd1);
    chk("lat_e22_byte", {24'd0, oByte}, 32'hA5);
    repeat (6) cyc();
    chk("single_end_vld", {31'd0, oValid}, 32'd0);
    check_frames("single");

    // Backpressure: ready pattern 1,0,0,1 while a frame is presented
    n_hs = 0; chk_stall = 1'b1;
    iTDC = 10'h0F3; iDone = 1'b1; q_rec.push_back({n_edge[13:0], 10'h0F3});
    cyc(); iDone = 1'b0;
    for (int i = 0; i < 24; i++) begin
      iReady = (i % 4 == 0) || (i % 4 == 3);
      cyc();
    end
    chk_stall = 1'b0; iReady = 1'b1;
    chk("bp_hs", n_hs, 4);
    check_frames("bp");

    // Burst of 5 consecutive hits with ready held high
    n_hs = 0; first_hs = -1; max_lvl = 0;
    for (int i = 0; i < 5; i++) begin
      iTDC = 10'(i * 37 + 5); iDone = 1'b1;
      q_rec.push_back({n_edge[13:0], 10'(i * 37 + 5)});
      cyc();
    end
    iDone = 1'b0;
    repeat (24) cyc();
    chk("burst_hs", n_hs, 20);
    chk("burst_span", last_hs - first_hs, 19);
    chk("burst_peak", max_lvl, 4);
    check_frames("burst");

    // Overflow: one frame stuck in the serializer, then 17 hits into a 16-deep FIFO
    iReady = 1'b0;
    iTDC = 10'h3FF; iDone = 1'b1; q_rec.push_back({n_edge[13:0], 10'h3FF});
    cyc(); iDone = 1'b0;
    repeat (3) cyc();
    chk("ovf_pre_lvl", {27'd0, oLevel}, 32'd0);
    chk("ovf_pre_vld", {31'd0, oValid}, 32'd1);
    for (int i = 0; i < 17; i++) begin
      iTDC = 10'(i); iDone = 1'b1;
      if (i < 16) q_rec.push_back({n_edge[13:0], 10'(i)});
      cyc();
      if (i == 15) begin
        chk("ovf_lvl16", {27'd0, oLevel}, 32'd16);
        chk("ovf_not_yet", {31'd0, oOverflow}, 32'd0);
      end
    end
    iDone = 1'b0;
    chk("ovf_lvl_full", {27'd0, oLevel}, 32'd16);
    chk("ovf_set", {31'd0, oOverflow}, 32'd1);
    iReady = 1'b1; n_hs = 0;
    repeat (80) cyc();
    chk("drain_lvl", {27'd0, oLevel}, 32'd0);
    chk("drain_hs", n_hs, 68);
    chk("ovf_sticky", {31'd0, oOverflow}, 32'd1);
    check_frames("ovf");
    iClrOvf = 1'b1; cyc(); iClrOvf = 1'b0;
    chk("ovf_clr", {31'd0, oOverflow}, 32'd0);

    // Coarse wrap: hit at edge 2^14+4 carries coarse field 4
    do_reset();
    iReady = 1'b1;
    repeat (16388) cyc();
    iTDC = 10'h155; iDone = 1'b1; q_rec.push_back({14'd4, 10'h155});
    cyc(); iDone = 1'b0;
    repeat (8) cyc();
    check_frames("wrap");

    // Reset during B1 aborts the frame at once
    n_hs = 0;
    iTDC = 10'h2AA; iDone = 1'b1;
    cyc(); iDone = 1'b0;
    guard = 0;
    while (n_hs < 2 && guard < 20) begin
      cyc();
      guard++;
    end
    chk("b1_reached", n_hs, 2);
    chk("b1_vld", {31'd0, oValid}, 32'd1);
    iRst = 1'b1;
    #1;
    chk("abort_vld", {31'd0, oValid}, 32'd0);
    chk("abort_byte", {24'd0, oByte}, 32'd0);
    chk("abort_lvl", {27'd0, oLevel}, 32'd0);
    q_b.delete(); q_rec.delete();
    #2;
    iRst = 1'b0; n_edge = 0;
    repeat (4) cyc();
    chk("post_rst_vld", {31'd0, oValid}, 32'd0);
    chk("post_rst_nobytes", q_b.size(), 0);
    iTDC = 10'h01C; iDone = 1'b1; q_rec.push_back({n_edge[13:0], 10'h01C});
    cyc(); iDone = 1'b0;
    repeat (8) cyc();
    check_frames("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
